// File: rtl/strobe_block_counter.sv
// Strobe block counter: groups single-cycle word strobes into blocks of a
// configurable length, tracks completed blocks in a small pending counter
// with a valid/ready pop handshake, and flags dropped blocks in a sticky
// overflow bit.
module strobe_block_counter #(
  parameter int CNT_W  = 3,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              o_strob,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic              clear,
  input  logic              blk_ready,
  output logic              blk_valid,
  output logic [PEND_W-1:0] pend_cnt,
  output logic [CNT_W-1:0]  word_idx,
  output logic              strb_first,
  output logic              strb_last,
  output logic              overflow
);

  localparam logic [CNT_W-1:0]  IDX_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  IDX_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE  = {{(PEND_W-1){1'b0}}, 1'b1};
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

  logic [CNT_W-1:0]  word_idx_q, word_idx_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;

  logic              at_start_s;
  logic [CNT_W-1:0]  eff_len_s;
  logic [CNT_W-1:0]  last_idx_s;
  logic              complete_s;
  logic              pop_s;

  // Group-boundary detection; length 0 wraps to an all-ones last index.
  always_comb begin
    at_start_s = (word_idx_q == IDX_ZERO);
    if (at_start_s) begin
      eff_len_s = cfg_len;
    end else begin
      eff_len_s = len_q;
    end
    last_idx_s = eff_len_s - IDX_ONE;
    complete_s = o_strob && (word_idx_q == last_idx_s);
    pop_s      = valid_q && blk_ready;
  end

  // Next-state logic for index, latched length, pending count and overflow.
  always_comb begin
    word_idx_d = word_idx_q;
    len_d      = len_q;
    pend_d     = pend_q;
    ovf_d      = ovf_q;
    if (clear) begin
      // Soft clear wins over any strobe or pop in the same cycle.
      word_idx_d = IDX_ZERO;
      len_d      = cfg_len;
      pend_d     = PEND_ZERO;
      ovf_d      = 1'b0;
    end else begin
      // Length is only sampled while sitting at the group start.
      if (at_start_s) begin
        len_d = cfg_len;
      end else begin
        len_d = len_q;
      end
      if (o_strob) begin
        if (complete_s) begin
          word_idx_d = IDX_ZERO;
        end else begin
          word_idx_d = word_idx_q + IDX_ONE;
        end
      end else begin
        word_idx_d = word_idx_q;
      end
      if (complete_s && !pop_s) begin
        if (pend_q == PEND_MAX) begin
          // No room: the completed group is dropped.
          pend_d = pend_q;
          ovf_d  = 1'b1;
        end else begin
          pend_d = pend_q + PEND_ONE;
        end
      end else if (pop_s && !complete_s) begin
        pend_d = pend_q - PEND_ONE;
      end else begin
        pend_d = pend_q;
      end
    end
    valid_d = (pend_d != PEND_ZERO);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_idx_q <= IDX_ZERO;
      len_q      <= IDX_ZERO;
      pend_q     <= PEND_ZERO;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      word_idx_q <= word_idx_d;
      len_q      <= len_d;
      pend_q     <= pend_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign blk_valid  = valid_q;
  assign pend_cnt   = pend_q;
  assign word_idx   = word_idx_q;
  assign overflow   = ovf_q;
  assign strb_first = o_strob && at_start_s;
  assign strb_last  = complete_s;

endmodule

// File: tb/tb_strobe_block_counter.sv
// Self-checking bench for strobe_block_counter (CNT_W=3, PEND_W=2).
// A reference model predicts each cycle's outputs at drive time and pushes
// them to a scoreboard queue; each test task pops and compares after the edge,
// and also checks directed constant expectations.
module tb_strobe_block_counter;

  logic       clk;
  logic       reset_n;
  logic       o_strob;
  logic [2:0] cfg_len;
  logic       clear;
  logic       blk_ready;
  logic       blk_valid;
  logic [1:0] pend_cnt;
  logic [2:0] word_idx;
  logic       strb_first;
  logic       strb_last;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  // {first, last, word_idx, pend_cnt, blk_valid, overflow}
  typedef logic [8:0] exp_t;
  exp_t sb[$];
  exp_t e;

  logic [2:0] m_idx, m_len;
  logic [1:0] m_pend;
  logic       m_ovf;
  logic       c_first, c_last;

  strobe_block_counter #(.CNT_W(3), .PEND_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .o_strob(o_strob), .cfg_len(cfg_len),
    .clear(clear), .blk_ready(blk_ready), .blk_valid(blk_valid),
    .pend_cnt(pend_cnt), .word_idx(word_idx), .strb_first(strb_first),
    .strb_last(strb_last), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_idx = 3'd0; m_len = 3'd0; m_pend = 2'd0; m_ovf = 1'b0;
  endtask

  // Drive one cycle, capture combinational outputs before the edge,
  // push the model prediction, and return 1 time unit after the edge.
  task automatic drive(input logic s, input logic r, input logic c, input logic [2:0] l);
    logic [2:0] eff, lastv;
    logic comp, pop, ef;
    @(negedge clk);
    o_strob = s; blk_ready = r; clear = c; cfg_len = l;
    #1;
    c_first = strb_first;
    c_last  = strb_last;
    eff   = (m_idx == 3'd0) ? l : m_len;
    lastv = eff - 3'd1;
    comp  = s && (m_idx == lastv);
    pop   = r && (m_pend != 2'd0);
    ef    = s && (m_idx == 3'd0);
    if (c) begin
      m_idx = 3'd0; m_len = l; m_pend = 2'd0; m_ovf = 1'b0;
    end else begin
      if (m_idx == 3'd0) m_len = l;
      if (s) m_idx = comp ? 3'd0 : m_idx + 3'd1;
      if (comp && !pop) begin
        if (m_pend == 2'd3) m_ovf = 1'b1;
        else m_pend = m_pend + 2'd1;
      end else if (pop && !comp) begin
        m_pend = m_pend - 2'd1;
      end
    end
    sb.push_back({ef, comp, m_idx, m_pend, (m_pend != 2'd0), m_ovf});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; o_strob = 1'b0; cfg_len = 3'd0; clear = 1'b0; blk_ready = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({word_idx, pend_cnt, blk_valid, overflow, strb_first, strb_last} !== 9'd0) begin
      failures++;
      $display("FAIL reset_state: got %b exp %b",
               {word_idx, pend_cnt, blk_valid, overflow, strb_first, strb_last}, 9'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [2:0] exp_idx [4];
    exp_idx[0] = 3'd1; exp_idx[1] = 3'd2; exp_idx[2] = 3'd3; exp_idx[3] = 3'd0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'd4);
      e = sb.pop_front();
      checks++;
      if ({c_first, c_last, word_idx, pend_cnt, blk_valid, overflow} !== e) begin
        failures++;
        $display("FAIL basic_sb[%0d]: got %b exp %b", i,
                 {c_first, c_last, word_idx, pend_cnt, blk_valid, overflow}, e);
      end
      checks++;
      if ({word_idx, c_last, blk_valid} !== {exp_idx[i], (i == 3), (i == 3)}) begin
        failures++;
        $display("FAIL basic_seq[%0d]: idx=%0d last=%b valid=%b exp idx=%0d", i,
                 word_idx, c_last, blk_valid, exp_idx[i]);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 3'd4);
    e = sb.pop_front();
    checks++;
    if (blk_valid !== 1'b0 || pend_cnt !== 2'd0) begin
      failures++;
      $display("FAIL basic_valid_one_cycle: valid=%b pend=%0d exp 0 0", blk_valid, pend_cnt);
    end
  endtask

  task automatic test_full_len();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 3'd0);
      e = sb.pop_front();
      checks++;
      if ({c_first, c_last, word_idx, pend_cnt, blk_valid, overflow} !== e) begin
        failures++;
        $display("FAIL full_sb[%0d]: got %b exp %b", i,
                 {c_first, c_last, word_idx, pend_cnt, blk_valid, overflow}, e);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 3'd0);
      e = sb.pop_front();
      checks++;
      if (pend_cnt !== 2'd1 || blk_valid !== 1'b1) begin
        failures++;
        $display("FAIL full_hold[%0d]: pend=%0d valid=%b exp 1 1", i, pend_cnt, blk_valid);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 3'd0);
    e = sb.pop_front();
    checks++;
    if (pend_cnt !== 2'd0 || blk_valid !== 1'b0 || e[3:2] !== 2'd0) begin
      failures++;
      $display("FAIL full_pop: pend=%0d valid=%b exp 0 0", pend_cnt, blk_valid);
    end
  endtask

  task automatic test_overflow();
    logic [1:0] exp_p [4];
    exp_p[0] = 2'd1; exp_p[1] = 2'd2; exp_p[2] = 2'd3; exp_p[3] = 2'd3;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 3'd1);
      e = sb.pop_front();
      checks++;
      if ({pend_cnt, overflow, word_idx, c_first, c_last} !== {exp_p[i], (i == 3), 3'd0, 1'b1, 1'b1}) begin
        failures++;
        $display("FAIL ovf_seq[%0d]: pend=%0d ovf=%b idx=%0d first=%b last=%b", i,
                 pend_cnt, overflow, word_idx, c_first, c_last);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 3'd1);
    e = sb.pop_front();
    checks++;
    if (overflow !== 1'b1 || {c_first, c_last, word_idx, pend_cnt, blk_valid, overflow} !== e) begin
      failures++;
      $display("FAIL ovf_sticky: ovf=%b got %b exp %b", overflow,
               {c_first, c_last, word_idx, pend_cnt, blk_valid, overflow}, e);
    end
    drive(1'b1, 1'b1, 1'b1, 3'd1);
    e = sb.pop_front();
    checks++;
    if ({pend_cnt, overflow, blk_valid, word_idx} !== 7'd0) begin
      failures++;
      $display("FAIL ovf_clear: pend=%0d ovf=%b valid=%b idx=%0d exp all 0",
               pend_cnt, overflow, blk_valid, word_idx);
    end
  endtask

  task automatic test_simul_and_len_latch();
    drive(1'b1, 1'b0, 1'b0, 3'd1);
    e = sb.pop_front();
    drive(1'b1, 1'b0, 1'b0, 3'd1);
    e = sb.pop_front();
    checks++;
    if (pend_cnt !== 2'd2) begin
      failures++;
      $display("FAIL simul_setup: pend=%0d exp 2", pend_cnt);
    end
    drive(1'b1, 1'b0, 1'b0, 3'd4);
    e = sb.pop_front();
    drive(1'b1, 1'b0, 1'b0, 3'd4);
    e = sb.pop_front();
    drive(1'b1, 1'b0, 1'b0, 3'd2);
    e = sb.pop_front();
    checks++;
    if (c_last !== 1'b0 || word_idx !== 3'd3) begin
      failures++;
      $display("FAIL len_latch_mid: last=%b idx=%0d exp 0 3", c_last, word_idx);
    end
    drive(1'b1, 1'b1, 1'b0, 3'd2);
    e = sb.pop_front();
    checks++;
    if ({c_last, word_idx, pend_cnt, blk_valid} !== {1'b1, 3'd0, 2'd2, 1'b1}) begin
      failures++;
      $display("FAIL simul_pop_complete: last=%b idx=%0d pend=%0d valid=%b exp 1 0 2 1",
               c_last, word_idx, pend_cnt, blk_valid);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 3'd2);
      e = sb.pop_front();
      checks++;
      if ({c_first, c_last, word_idx, pend_cnt, blk_valid, overflow} !== e) begin
        failures++;
        $display("FAIL drain_sb[%0d]: got %b exp %b", i,
                 {c_first, c_last, word_idx, pend_cnt, blk_valid, overflow}, e);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 1'b0, 3'd1);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 3'd0);
      e = sb.pop_front();
    end
    checks++;
    if (word_idx !== 3'd5 || pend_cnt !== 2'd1) begin
      failures++;
      $display("FAIL areset_setup: idx=%0d pend=%0d exp 5 1", word_idx, pend_cnt);
    end
    @(negedge clk);
    o_strob = 1'b0; blk_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({word_idx, pend_cnt, blk_valid, overflow, strb_first, strb_last} !== 9'd0) begin
      failures++;
      $display("FAIL areset_immediate: got %b exp %b",
               {word_idx, pend_cnt, blk_valid, overflow, strb_first, strb_last}, 9'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 3'd3);
    e = sb.pop_front();
    checks++;
    if (c_first !== 1'b1 || word_idx !== 3'd1 || e !== {c_first, c_last, word_idx, pend_cnt, blk_valid, overflow}) begin
      failures++;
      $display("FAIL areset_first: first=%b idx=%0d got %b exp %b", c_first, word_idx,
               {c_first, c_last, word_idx, pend_cnt, blk_valid, overflow}, e);
    end
  endtask

  task automatic test_random();
    logic s, r, c;
    logic [2:0] l;
    for (int i = 0; i < 200; i++) begin
      s = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 40) == 0);
      l = 3'($urandom_range(0, 7));
      drive(s, r, c, l);
      e = sb.pop_front();
      checks++;
      if ({c_first, c_last, word_idx, pend_cnt, blk_valid, overflow} !== e) begin
        failures++;
        $display("FAIL random_sb[%0d]: got %b exp %b", i,
                 {c_first, c_last, word_idx, pend_cnt, blk_valid, overflow}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_len();
    test_overflow();
    test_simul_and_len_latch();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/strobe_block_counter.md
STROBE_BLOCK_COUNTER -- requirements
Module: strobe_block_counter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
 - CNT_W, 3, width of strobe index and group-length config
 - PEND_W, 2, width of pending-group counter; max pending = 2^PEND_W-1
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
 - clk, in, 1, single clock, all state on rising edge
 - reset_n, in, 1, asynchronous active-low reset
 - o_strob, in, 1, one-cycle word strobe, counted when high
 - cfg_len, in, CNT_W, group length in strobes; 0 means 2^CNT_W
 - clear, in, 1, synchronous soft clear
 - blk_ready, in, 1, consumer accepts one completed group
 - blk_valid, out, 1, at least one completed group pending
 - pend_cnt, out, PEND_W, number of completed groups pending
 - word_idx, out, CNT_W, index of the next strobe within current group
 - strb_first, out, 1, combinational: o_strob and word_idx==0
 - strb_last, out, 1, combinational: o_strob and strobe completes group
 - overflow, out, 1, sticky: a completed group was dropped
REQ-003 Clock SHALL be named clk; reset SHALL be reset_n, asynchronous, active-low; there is exactly one clock domain.

Function
REQ-004 Effective length L SHALL be cfg_len when word_idx==0, else latched len_q; len_q SHALL load cfg_len on every cycle with word_idx==0, so cfg_len changes mid-group have no effect until the next group.
REQ-005 A strobe SHALL complete a group when word_idx == L-1 computed modulo 2^CNT_W (L=0 -> last index all-ones).
REQ-006 On o_strob without completion, word_idx SHALL increment by 1; on completion word_idx SHALL return to 0.
REQ-007 With L=1 every strobe SHALL complete a group; strb_first and strb_last both high.
REQ-008 No strobe: word_idx, len_q SHALL hold (except REQ-004 reload at index 0).
REQ-009 pop = blk_valid and blk_ready; blk_valid SHALL equal (pend_cnt != 0), driven from registered pend_cnt.
REQ-010 Completion only: pend_cnt +1. Pop only: pend_cnt -1. Completion and pop same cycle: pend_cnt unchanged.
REQ-011 Latency: strobe completing a group in cycle t SHALL raise blk_valid in cycle t+1 when pend_cnt was 0.
REQ-012 Completion with pend_cnt at max (2^PEND_W-1) and no pop: group SHALL be dropped, pend_cnt holds max, overflow SHALL set; word_idx still wraps to 0.
REQ-013 overflow SHALL remain high until reset_n low or clear.
REQ-014 blk_ready while blk_valid low SHALL have no effect; pend_cnt never underflows.
REQ-015 clear SHALL, next edge, set word_idx=0, pend_cnt=0, overflow=0, len_q=cfg_len, overriding any strobe or pop that cycle.
REQ-016 strb_first/strb_last SHALL be purely combinational from o_strob, word_idx, L; all other outputs registered.

Reset
REQ-017 reset_n low SHALL asynchronously force word_idx=0, len_q=0, pend_cnt=0, blk_valid=0, overflow=0; release is synchronous to clk.
REQ-018 Reset asserted mid-group or with groups pending SHALL discard all progress; first strobe after release is index 0.
REQ-019 No output SHALL be X after reset while inputs are known.

Verification
REQ-020 CNT_W=3, cfg_len=4, blk_ready=1, 4 strobes on consecutive cycles -> word_idx 0,1,2,3,0; strb_last on 4th; blk_valid high exactly one cycle, one cycle after 4th strobe.
REQ-021 cfg_len=0, 8 strobes, blk_ready=0 -> pend_cnt=1, blk_valid held high until blk_ready pulsed, then pend_cnt=0.
REQ-022 PEND_W=2, cfg_len=1, blk_ready=0, 4 strobes -> pend_cnt 1,2,3,3; overflow set on 4th; then clear -> pend_cnt=0, overflow=0.
REQ-023 pend_cnt=2, completing strobe with blk_ready=1 same cycle -> pend_cnt stays 2; cfg_len changed 4->2 at word_idx=2 -> group still completes at index 3.
REQ-024 reset_n pulsed low asynchronously at word_idx=5, pend_cnt=1 -> all outputs 0 immediately, next strobe reports strb_first.
